bist_addr_seq: RTL and testbench
================================

BIST_ADDR_SEQ -- requirements
Module: bist_addr_seq

Interface
REQ-001 Parameter AD_W, default 8: address width in bits.
REQ-002 Parameter COL_W, default 4: column-field width; 1 <= COL_W < AD_W.
REQ-003 The design SHALL use clock clk; reset reset, synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin a sweep; sampled in IDLE or DONE.
REQ-007 up_down  input  1  sweep direction (1=ascending, 0=descending); captured on accepted start.
REQ-008 lo  input  AD_W  lower bound, inclusive; captured on accepted start.
REQ-009 hi  input  AD_W  upper bound, inclusive; captured on accepted start.
REQ-010 adv  input  1  advance one address; valid only in RUN.
REQ-011 row_fast  input  1  row-fast address ordering; captured on accepted start.
REQ-012 address  output  AD_W  current memory address.
REQ-013 last  output  1  current address is the final address of the sweep.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse when a sweep completes.
REQ-016 err  output  1  sticky bound error (lo > hi).

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; DONE behaves as IDLE except that it is a distinct encoding.
REQ-018 On start in IDLE/DONE with lo <= hi, the block SHALL capture the inputs, load cnt <= (up_down ? lo : hi), clear err, and enter RUN on the next cycle.
REQ-019 On start with lo > hi, the block SHALL set err, leave cnt unchanged, and remain in or return to IDLE.
REQ-020 start in RUN SHALL be ignored.
REQ-021 In RUN with adv=1 and last=0, cnt SHALL step +1 (ascending) or -1 (descending), taking effect on the next cycle.
REQ-022 In RUN with adv=1 and last=1, the block SHALL enter DONE, assert done for exactly that one next cycle, hold cnt, and drop busy.
REQ-023 last SHALL equal RUN && (cnt == (up_down ? hi : lo)), combinational from registered state.
REQ-024 The terminal-compare-before-step rule SHALL guarantee that the full range lo=0, hi=2^AD_W-1 never wraps.
REQ-025 When lo == hi, the sweep SHALL be exactly one address, with last=1 from the first RUN cycle.
REQ-026 adv=0 SHALL hold all state; adv outside RUN SHALL be ignored.
REQ-027 address SHALL be the mapped cnt (see Configuration), with zero latency from cnt.

Reset
REQ-028 Reset SHALL force state IDLE, cnt=0, address=0, last=0, busy=0, done=0, err=0 and captured registers=0.
REQ-029 Reset SHALL dominate start and adv in the same cycle, including when asserted mid-sweep.

Configuration
REQ-030 With ROW_FAST_EN defined and the captured row_fast=1, the outputs SHALL be address[AD_W-1:COL_W]=cnt[AD_W-COL_W-1:0] and address[COL_W-1:0]=cnt[AD_W-1:AD_W-COL_W], so the row field varies fastest.
REQ-031 Without ROW_FAST_EN, or with row_fast=0, address SHALL equal cnt; the row_fast port SHALL remain present but be ignored.

Structure
REQ-032 Shared package bist_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default AD_W/COL_W constants.
REQ-033 The address mapping SHALL be placed in the combinational sub-module bist_addr_map.

Verification
REQ-034 AD_W=8, start lo=3, hi=6, up_down=1, adv held high -> address 3,4,5,6; last only on 6; done pulses one cycle later; busy then 0.
REQ-035 lo=0, hi=255, up_down=0 -> address 255 down to 0 (256 addresses), no wrap; done once.
REQ-036 start with lo=9, hi=2 -> err=1, state stays IDLE, busy=0; a subsequent valid start clears err.
REQ-037 Reset asserted with cnt=5 mid-sweep, concurrent with adv=1 -> next cycle all outputs 0, state IDLE.
REQ-038 ROW_FAST_EN, AD_W=8, COL_W=4, row_fast=1, lo=0, hi=2 -> address 0x00, 0x10, 0x20.
REQ-039 lo=hi=7 -> single RUN cycle with last=1; adv -> done; start asserted during RUN is ignored.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and default geometry for the BIST address sequencer.
package bist_pkg;

  localparam int unsigned AD_W_DEF  = 8;
  localparam int unsigned COL_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bist_addr_map.sv
// Combinational counter-to-address mapping; row_fast_i rotates the row field into the low bits.
module bist_addr_map #(
  parameter int unsigned AD_W  = 8,
  parameter int unsigned COL_W = 4
) (
  input  logic [AD_W-1:0] cnt_i,
  input  logic            row_fast_i,
  output logic [AD_W-1:0] addr_o
);

  always_comb begin
    addr_o = cnt_i;
    if (row_fast_i) begin
      addr_o = {cnt_i[AD_W-COL_W-1:0], cnt_i[AD_W-1:AD_W-COL_W]};
    end
  end

endmodule

// File: rtl/bist_addr_seq.sv
// BIST address sequencer: sweeps lo..hi up or down, one step per adv.
// Row-fast ordering is compiled in only when ROW_FAST_EN is defined.
module bist_addr_seq
  import bist_pkg::*;
#(
  parameter int unsigned AD_W  = AD_W_DEF,
  parameter int unsigned COL_W = COL_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            up_down,
  input  logic [AD_W-1:0] lo,
  input  logic [AD_W-1:0] hi,
  input  logic            adv,
  input  logic            row_fast,
  output logic [AD_W-1:0] address,
  output logic            last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state_q;
  logic [AD_W-1:0] cnt_q;
  logic [AD_W-1:0] lo_q;
  logic [AD_W-1:0] hi_q;
  logic            up_down_q;
  logic            row_fast_q;
  logic            done_q;
  logic            err_q;
  logic            last_w;
  logic            map_en;

  // Terminal compare happens before any step, so a full-range sweep never wraps.
  always_comb begin
    last_w = (state_q == RUN) && (cnt_q == (up_down_q ? hi_q : lo_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      up_down_q  <= 1'b0;
      row_fast_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (lo <= hi) begin
              lo_q       <= lo;
              hi_q       <= hi;
              up_down_q  <= up_down;
              row_fast_q <= row_fast;
              cnt_q      <= up_down ? lo : hi;
              err_q      <= 1'b0;
              state_q    <= RUN;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        RUN: begin
          if (adv) begin
            if (last_w) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (up_down_q) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef ROW_FAST_EN
    map_en = row_fast_q;
`else
    map_en = row_fast_q & 1'b0;
`endif
  end

  bist_addr_map #(
    .AD_W  (AD_W),
    .COL_W (COL_W)
  ) u_map (
    .cnt_i      (cnt_q),
    .row_fast_i (map_en),
    .addr_o     (address)
  );

  assign last = last_w;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bist_addr_seq.sv
// Self-checking bench for bist_addr_seq: directed scenarios plus random traffic vs a sweep-list model.
module tb_bist_addr_seq;

  localparam int AD_W  = 8;
  localparam int COL_W = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            up_down = 1'b0;
  logic [AD_W-1:0] lo = '0;
  logic [AD_W-1:0] hi = '0;
  logic            adv = 1'b0;
  logic            row_fast = 1'b0;
  logic [AD_W-1:0] address;
  logic            last;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int failures = 0;

  bist_addr_seq #(
    .AD_W  (AD_W),
    .COL_W (COL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .up_down  (up_down),
    .lo       (lo),
    .hi       (hi),
    .adv      (adv),
    .row_fast (row_fast),
    .address  (address),
    .last     (last),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Model: a sweep is the explicit list of addresses it will visit.
  bit m_run, m_err, m_done;
  int m_addr, m_idx;
  int sweep[$];

  function automatic int map_addr(int c, bit rf);
`ifdef ROW_FAST_EN
    if (rf) return (c % (1 << (AD_W - COL_W))) * (1 << COL_W) + c / (1 << (AD_W - COL_W));
`endif
    return c;
  endfunction

  task automatic model_step(input bit rst, st, ud, input int l, h, input bit a, rf);
    if (rst) begin
      m_run = 0; m_err = 0; m_done = 0; m_addr = 0; m_idx = 0;
      sweep.delete();
      return;
    end
    m_done = 0;
    if (!m_run) begin
      if (st) begin
        if (l <= h) begin
          sweep.delete();
          if (ud) for (int v = l; v <= h; v++) sweep.push_back(map_addr(v, rf));
          else    for (int v = h; v >= l; v--) sweep.push_back(map_addr(v, rf));
          m_idx = 0; m_run = 1; m_err = 0; m_addr = sweep[0];
        end else begin
          m_err = 1;
        end
      end
    end else if (a) begin
      if (m_idx == sweep.size() - 1) begin
        m_run = 0; m_done = 1;
      end else begin
        m_idx++;
        m_addr = sweep[m_idx];
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("address", int'(address), m_addr);
    chk("last", int'(last), int'(m_run && (m_idx == sweep.size() - 1)));
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    chk("err", int'(err), int'(m_err));
  endtask

  task automatic tick(input bit rst, st, ud, input int l, h, input bit a, rf);
    reset = rst; start = st; up_down = ud;
    lo = AD_W'(l); hi = AD_W'(h); adv = a; row_fast = rf;
    model_step(rst, st, ud, l, h, a, rf);
    @(negedge clk);
    compare_all();
  endtask

  int dcount;

  initial begin
    // Reset state
    tick(1, 1, 1, 3, 6, 1, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("rst_addr", int'(address), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    // Ascending 3..6
    tick(0, 1, 1, 3, 6, 0, 0);
    chk("asc_first", int'(address), 3);
    chk("asc_busy", int'(busy), 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("asc_nolast", int'(last), 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("asc_end", int'(address), 6);
    chk("asc_last", int'(last), 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("asc_done", int'(done), 1);
    chk("asc_busy_off", int'(busy), 0);
    chk("asc_hold", int'(address), 6);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("asc_done_pulse", int'(done), 0);

    // Bound error then recovery
    tick(0, 1, 1, 9, 2, 0, 0);
    chk("err_set", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("err_sticky", int'(err), 1);
    tick(0, 1, 0, 1, 1, 0, 0);
    chk("err_clear", int'(err), 0);
    tick(0, 0, 0, 0, 0, 1, 0);

    // Single-address sweep; start during RUN ignored
    tick(0, 1, 1, 7, 7, 0, 0);
    chk("one_last", int'(last), 1);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("one_ign", int'(address), 7);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("one_done", int'(done), 1);

    // Reset mid-sweep with adv and start
    tick(0, 1, 1, 0, 10, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 1, 0);
    chk("mid_cnt", int'(address), 5);
    tick(1, 1, 1, 0, 10, 1, 0);
    chk("mid_rst_addr", int'(address), 0);
    chk("mid_rst_busy", int'(busy), 0);

    // Full descending range, no wrap
    tick(0, 1, 0, 0, 255, 0, 0);
    chk("full_first", int'(address), 255);
    dcount = 0;
    for (int i = 0; i < 255; i++) begin
      tick(0, 0, 0, 0, 0, 1, 0);
      dcount += int'(done);
    end
    chk("full_end", int'(address), 0);
    chk("full_last", int'(last), 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    dcount += int'(done);
    tick(0, 0, 0, 0, 0, 1, 0);
    dcount += int'(done);
    chk("full_done_once", dcount, 1);
    chk("full_hold", int'(address), 0);

`ifdef ROW_FAST_EN
    tick(0, 1, 1, 0, 2, 0, 1);
    chk("rf0", int'(address), 8'h00);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("rf1", int'(address), 8'h10);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("rf2", int'(address), 8'h20);
    tick(0, 0, 0, 0, 0, 1, 0);
`else
    tick(0, 1, 1, 0, 2, 0, 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("rf_ignored", int'(address), 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int l, h, sel;
      sel = int'($urandom_range(0, 19));
      l = int'($urandom_range(0, 255));
      if (sel == 0) begin
        l = 0; h = 255;
      end else if (sel < 3) begin
        h = int'($urandom_range(0, 255));
      end else begin
        h = l + int'($urandom_range(0, 6));
        if (h > 255) h = 255;
      end
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), 1'($urandom),
           l, h, ($urandom_range(0, 9) < 7), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
